pwm_cfg_sequencer: RTL

AXI4-Lite master that programs the PWM peripheral's register bank from a parallel configuration word.
Each start request writes C_NUM_REGS consecutive 32-bit registers from C_BASE_ADDR. Each write is optionally read back and compared, so the fabric can reconfigure the PWM without a processor.
It sits between fabric control logic and the PWM slave's S00_AXI port.

---
 rtl/pwm_cfg_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_cfg_sequencer.sv
// AXI4-Lite master that writes a bank of PWM configuration registers from a
// parallel word, optionally reading each one back and comparing it.
module pwm_cfg_sequencer #(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
   parameter int          C_NUM_REGS         = 4,
   parameter int          C_VERIFY           = 1
) (
   input  logic                                       ACLK,
   input  logic                                       ARESETN,
   input  logic                                       start,
   input  logic [C_NUM_REGS*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       error,
   output logic [3:0]                                 err_index,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_AWADDR,
   output logic [2:0]                                 M_AXI_AWPROT,
   output logic                                       M_AXI_AWVALID,
   input  logic                                       M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_WDATA,
   output logic [3:0]                                 M_AXI_WSTRB,
   output logic                                       M_AXI_WVALID,
   input  logic                                       M_AXI_WREADY,
   input  logic [1:0]                                 M_AXI_BRESP,
   input  logic                                       M_AXI_BVALID,
   output logic                                       M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]              M_AXI_ARADDR,
   output logic [2:0]                                 M_AXI_ARPROT,
   output logic                                       M_AXI_ARVALID,
   input  logic                                       M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]              M_AXI_RDATA,
   input  logic [1:0]                                 M_AXI_RRESP,
   input  logic                                       M_AXI_RVALID,
   output logic                                       M_AXI_RREADY
);

   // state  | meaning
   // IDLE   | waiting for start
   // WRITE  | AW and W channels in flight, each completes independently
   // WRESP  | waiting for the write response
   // RADDR  | read-back address in flight
   // RDATA  | waiting for read-back data, compare against shadow
   // NEXT   | advance to next register or finish
   // FINISH | one-cycle done pulse
   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_NEXT, S_FINISH
   } state_t;

   localparam int                            DW       = C_M_AXI_DATA_WIDTH;
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE     = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR);
   localparam logic [3:0]                    LAST_IDX = 4'(C_NUM_REGS - 1);

   state_t                              state_q, state_d;
   logic [3:0]                          idx_q, idx_d;
   logic [C_NUM_REGS*DW-1:0]            shadow_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [DW-1:0]                       wdata_q, wdata_d;
   logic                                aw_done_q, aw_done_d;
   logic                                w_done_q, w_done_d;
   logic                                error_q, error_d;
   logic [3:0]                          err_index_q, err_index_d;
   logic                                aw_fire, w_fire;

   assign M_AXI_AWVALID = (state_q == S_WRITE) && !aw_done_q;
   assign M_AXI_WVALID  = (state_q == S_WRITE) && !w_done_q;
   assign M_AXI_BREADY  = (state_q == S_WRESP);
   assign M_AXI_ARVALID = (state_q == S_RADDR);
   assign M_AXI_RREADY  = (state_q == S_RDATA);
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = 4'hF;

   assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign done      = (state_q == S_FINISH);
   assign error     = error_q;
   assign err_index = err_index_q;

   assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
      end
   end

   // The shadow copy isolates the running sequence from later cfg_data changes.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         shadow_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         shadow_q <= cfg_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d       = 4'd0;
               addr_d      = BASE;
               wdata_d     = cfg_data[DW-1:0];
               aw_done_d   = 1'b0;
               w_done_d    = 1'b0;
               error_d     = 1'b0;
               err_index_d = 4'd0;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            aw_done_d = aw_done_q | aw_fire;
            w_done_d  = w_done_q | w_fire;
            if (aw_done_d && w_done_d) state_d = S_WRESP;
         end
         S_WRESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  error_d     = 1'b1;
                  err_index_d = idx_q;
                  state_d     = S_FINISH;
               end else if (C_VERIFY != 0) begin
                  state_d = S_RADDR;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_RADDR: begin
            if (M_AXI_ARREADY) state_d = S_RDATA;
         end
         S_RDATA: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != wdata_q) begin
                  error_d     = 1'b1;
                  err_index_d = idx_q;
                  state_d     = S_FINISH;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else begin
               idx_d     = idx_q + 4'd1;
               addr_d    = addr_q + C_M_AXI_ADDR_WIDTH'(4);
               wdata_d   = shadow_q[(int'(idx_q) + 1) * DW +: DW];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WRITE;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

endmodule
